// File: rtl/fp32_const_pkg.sv
// Shared constants and field layout for the fixed-constant FP32 multipliers
// in the exp/log datapath.
package fp32_const_pkg;

  localparam logic [23:0] LN2_Q24      = 24'hB17218;
  localparam logic [23:0] LOG2E_Q24    = 24'hB8AA3B;
  localparam logic [7:0]  EXPO_SPECIAL = 8'hFF;
  localparam int          EXPO_BIAS    = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
  } fp32_t;

endpackage

// File: rtl/mul_ln2_if.sv
// Operand/result bundle for mul_ln2. Handshake: a beat moves into the pipe on a
// rising edge with en=1 and vld_in=1; a result is new on an edge with en=1 that
// sets vld_out. en=0 freezes every stage, and there is no backpressure besides en.
interface mul_ln2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  vld_in;
  logic [DATA_WIDTH-1:0] operand_in;
  logic [DATA_WIDTH-1:0] result_out;
  logic                  vld_out;

  modport master (
    output en, vld_in, operand_in,
    input  result_out, vld_out
  );

  modport slave (
    input  en, vld_in, operand_in,
    output result_out, vld_out
  );
endinterface

// File: rtl/const_mul_24x24.sv
// Combinational 24x24 multiply by a constant, built as a shift-add over the
// constant's set bits. Shared by the fixed-constant FP multipliers.
module const_mul_24x24
  import fp32_const_pkg::*;
#(
  parameter logic [23:0] K = LN2_Q24
) (
  input  logic [23:0] a,
  output logic [47:0] p
);

  logic [47:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 24; i++) begin
      if (K[i]) acc = acc + ({24'd0, a} << i);
    end
    p = acc;
  end

endmodule

// File: rtl/mul_ln2.sv
// Three-stage FP32 x*ln2 with global stall and flush-to-zero.
// Define MUL_LN2_RNE_EN for round-to-nearest-even; default build truncates.
module mul_ln2
  import fp32_const_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic      clk,
  input  logic      rst,
  mul_ln2_if.slave  bus
);

  localparam int SW = MANT_WIDTH + 1;
  localparam int PW = 2 * SW;

  // S0
  logic [DATA_WIDTH-1:0] d0;
  logic                  v0;

  // S1
  fp32_t                 op;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         p1;
  logic                  s1, zero1, special1, v1;
  logic [EXPO_WIDTH-1:0] e1;

  // S2 combinational
  logic                  hi;
  logic [MANT_WIDTH-1:0] mant, mant_r;
  logic [EXPO_WIDTH-1:0] expo, expo_r;
  logic [DATA_WIDTH-1:0] res_c;

  assign op = fp32_t'(d0);

  const_mul_24x24 #(.K(LN2_Q24)) u_mul (
    .a ({1'b1, op.mant}),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0 <= '0;
      v0 <= 1'b0;
    end else if (bus.en) begin
      v0 <= bus.vld_in;
      if (bus.vld_in) d0 <= bus.operand_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1       <= '0;
      s1       <= 1'b0;
      e1       <= '0;
      zero1    <= 1'b0;
      special1 <= 1'b0;
      v1       <= 1'b0;
    end else if (bus.en) begin
      v1 <= v0;
      if (v0) begin
        p1       <= prod;
        s1       <= op.sign;
        e1       <= op.expo;
        zero1    <= (op.expo == '0);
        special1 <= (op.expo == EXPO_SPECIAL);
      end
    end
  end

  // The product of a [1,2) mantissa and ln2 lies in [0.69,1.39), so at most
  // one left shift is needed and the exponent can only drop by one.
  always_comb begin
    hi   = p1[PW-1];
    mant = hi ? p1[PW-2 -: MANT_WIDTH] : p1[PW-3 -: MANT_WIDTH];
    expo = hi ? e1 : e1 - 1'b1;
`ifdef MUL_LN2_RNE_EN
    begin
      logic g, st, rnd, carry;
      g     = hi ? p1[PW-2-MANT_WIDTH] : p1[PW-3-MANT_WIDTH];
      st    = hi ? (|p1[PW-3-MANT_WIDTH:0]) : (|p1[PW-4-MANT_WIDTH:0]);
      rnd   = g & (st | mant[0]);
      {carry, mant_r} = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, rnd};
      expo_r = carry ? expo + 1'b1 : expo;
    end
`else
    mant_r = mant;
    expo_r = expo;
`endif
    // Underflow is judged on the pre-rounding exponent.
    if (special1)
      res_c = {s1, EXPO_SPECIAL, {MANT_WIDTH{1'b0}}};
    else if (zero1 || (!hi && e1 == {{(EXPO_WIDTH-1){1'b0}}, 1'b1}))
      res_c = {s1, {(DATA_WIDTH-1){1'b0}}};
    else
      res_c = {s1, expo_r, mant_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result_out <= '0;
      bus.vld_out    <= 1'b0;
    end else if (bus.en) begin
      bus.vld_out <= v1;
      if (v1) bus.result_out <= res_c;
    end
  end

endmodule

// File: tb/tb_mul_ln2.sv
// Randomized and directed bench for mul_ln2 with a value-level reference model.
module tb_mul_ln2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ln2_if #(.DATA_WIDTH(32)) bus ();

  mul_ln2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rne_q[$];
  logic        en_q;
  logic [31:0] prev_res, last_res;
  logic        prev_vld, have_last;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // x*ln2 computed as an exact integer product, then normalized by locating
  // its leading one and rounding the discarded remainder against one half.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input bit rne);
    logic   s;
    int     e, n, shift, be;
    longint m, p, q, r, half;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 255) return {s, 8'hFF, 23'd0};
    if (e == 0)   return {s, 31'd0};
    m = longint'({1'b1, x[22:0]});
    p = m * longint'(24'hB17218);
    n = 62;
    while (n > 0 && p[n] == 1'b0) n--;
    be = n + e - 47;
    if (be <= 0) return {s, 31'd0};
    shift = n - 23;
    q = p >> shift;
    r = p - (q << shift);
    half = longint'(1) << (shift - 1);
    if (rne && (r > half || (r == half && q[0]))) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      be++;
    end
    return {s, be[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] ref_build(input logic [31:0] x);
`ifdef MUL_LN2_RNE_EN
    return ref_mul(x, 1'b1);
`else
    return ref_mul(x, 1'b0);
`endif
  endfunction

  always @(posedge clk) en_q <= bus.en;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!en_q) begin
        check("stall_data", bus.result_out, prev_res);
        check("stall_vld", {31'd0, bus.vld_out}, {31'd0, prev_vld});
      end else if (bus.vld_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected", bus.result_out, 32'hxxxxxxxx);
        end else begin
          logic [31:0] e, rn, diff;
          e  = exp_q.pop_front();
          rn = rne_q.pop_front();
          check("result", bus.result_out, e);
`ifndef MUL_LN2_RNE_EN
          diff = rn - bus.result_out;
          check("trunc_ulp", {31'd0, diff <= 32'd1}, 32'd1);
`else
          diff = rn;
`endif
          last_res  = e;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("hold", bus.result_out, last_res);
      end
    end
    prev_res = bus.result_out;
    prev_vld = bus.vld_out;
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic [31:0] exp);
    bus.vld_in     = v;
    bus.operand_in = d;
    bus.en         = e;
    if (v && e) begin
      exp_q.push_back(exp);
      rne_q.push_back(ref_mul(d, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] d);
    drive(1'b1, d, 1'b1, ref_build(d));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_result", bus.result_out, 32'd0);
    check("rst_vld", {31'd0, bus.vld_out}, 32'd0);
    exp_q.delete();
    rne_q.delete();
    have_last      = 1'b0;
    bus.en         = 1'b0;
    bus.vld_in     = 1'b0;
    bus.operand_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'd1;
      1:       e = 8'd0;
      2:       e = 8'hFF;
      3:       e = 8'd254;
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    int lat;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.vld_in = 1'b0;
    bus.operand_in = '0;
    have_last = 1'b0;
    #2;
    do_reset();

    // Latency and first value
    drive(1'b1, 32'h3F800000, 1'b1, 32'h3F317218);
    lat = 1;
    while (!bus.vld_out && lat < 10) begin
      drive(1'b0, 32'd0, 1'b1, 32'd0);
      lat++;
    end
    check("latency", lat, 3);
    idle(2);

    // Back-to-back, specials and flush cases
    drive(1'b1, 32'h40000000, 1'b1, 32'h3FB17218);
    drive(1'b1, 32'hC0000000, 1'b1, 32'hBFB17218);
    drive(1'b1, 32'hFF800000, 1'b1, 32'hFF800000);
    drive(1'b1, 32'h7FC00000, 1'b1, 32'h7F800000);
    drive(1'b1, 32'h00400000, 1'b1, 32'h00000000);
    drive(1'b1, 32'h80800000, 1'b1, 32'h80000000);
    idle(4);

    // Stall mid-stream with vld_in toggling
    op(32'h3FC00000);
    op(32'h40400000);
    op(32'hBF400000);
    for (int i = 0; i < 5; i++) drive(1'(i), $urandom, 1'b0, 32'd0);
    idle(5);

    // Bubble pattern
    op(32'h41200000);
    idle(1);
    op(32'hC2C80000);
    idle(4);

    // Reset with ops in flight
    op(32'h3F000000);
    op(32'h40A00000);
    op(32'h42000000);
    do_reset();
    idle(5);

    // Random sweep with random stalls and bubbles
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      logic v, e;
      d = rand_operand();
      v = ($urandom_range(0, 9) < 7);
      e = ($urandom_range(0, 9) < 8);
      drive(v, d, e, ref_build(d));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_ln2.md
Name: mul_ln2

Overview:
- Pipelined FP32 multiply by the constant ln2 (0.693147…), computing x·ln2.
- Converts a log2-domain value back to the natural-log domain; this is the inverse of the existing multiply-by-log2(e) stage in the FPU path.
- Sits in the exp/log datapath beside the other fixed-constant FP multipliers and uses the same en/valid pipeline style.
- Three register stages with a global stall enable; flush-to-zero semantics, no denormal support.

Parameters:
- DATA_WIDTH, 32, total FP word width
- EXPO_WIDTH, 8, exponent field width
- MANT_WIDTH, 23, stored mantissa width (hidden bit excluded)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  global pipeline enable; low = whole pipeline stalls
- vld_in  input  1  operand_in is valid this cycle
- operand_in  input  DATA_WIDTH  FP32 operand
- result_out  output  DATA_WIDTH  FP32 result
- vld_out  output  1  result_out is valid

Behaviour:
- Reset: async, active-high. While rst=1, all stage data registers, all valid registers, result_out and vld_out are 0.
- Stage valid bits (v0, v1, vld_out):
  - load on every cycle with en=1, including bubbles; v0<=vld_in, v1<=v0, vld_out<=v1.
  - hold while en=0.
- Stage data registers load only when en=1 AND that stage's incoming valid is 1; otherwise they hold.
- result_out therefore keeps its last valid value when vld_out=0.
- Latency: 3 enabled cycles, vld_in to vld_out. Throughput: 1 operand per cycle when en=1.
- Stage 0 (S0): register the operand.
- Stage 1 (S1):
  - Split the operand into s, E, M.
  - P = {1,M} (24b) × LN2_Q24 (24'hB17218), full 48-bit product.
  - Register P[47:0], s, E and class flags: zero = (E==0), special = (E==255).
- Stage 2 (S2), normalize:
  - If P[47]=1: mant=P[46:24], g=P[23], st=|P[22:0], expo=E.
  - Else: mant=P[45:23], g=P[22], st=|P[21:0], expo=E-1.
- Special cases, in priority order:
  - special → {s, 8'hFF, 23'd0}; NaN is not preserved.
  - zero → {s, 0, 0}.
  - P[47]=0 and E==1 → underflow, flushed to {s, 0, 0}.
- Otherwise the result is {s, expo, mant}, after optional rounding.
- Overflow cannot occur because |result| < |x|. The sign is passed through unchanged.
- If en falls with data mid-pipe, every stage holds its data and its valid bit; there is no loss and no duplication.
- Reset asserted mid-operation discards all in-flight data; vld_out=0 from the assertion edge.

Optional Feature:
- Macro: MUL_LN2_RNE_EN.
- Defined: round-to-nearest-even on mant using g, st and mant[0].
  - A mantissa carry-out gives mant=0, expo+1.
  - Rounding that lifts an E==1, P[47]=0 case up to 1.0·2^-126 is still flushed; underflow is decided before rounding.
- Undefined: truncation, with g and st ignored.
- Latency is identical either way.

Decomposition:
- Package fp32_const_pkg holds:
  - LN2_Q24 = 24'hB17218 and LOG2E_Q24 = 24'hB8AA3B
  - EXPO_SPECIAL = 8'hFF and EXPO_BIAS = 127
  - a typedef for the FP32 fields {sign, expo, mant}
- One sub-module: const_mul_24x24, a combinational 24×24 multiply by a constant, implemented as shift-add; it is reused by the other constant multipliers.

Test Plan:
- Reset, then en=1 and vld_in=1 for one cycle with operand 0x3F800000 (1.0) → after 3 cycles vld_out=1, result_out=0x3F317218 (both modes).
- Back-to-back 0x40000000 (2.0), 0xC0000000 (-2.0) → consecutive outputs 0x3FB17218 and 0xBFB17218, with vld_out high for 2 cycles.
- Specials and flush cases:
  - 0xFF800000 (-Inf) → 0xFF800000
  - 0x7FC00000 (NaN) → 0x7F800000
  - 0x00400000 (denormal) → 0x00000000
  - 0x80800000 (-min normal) → 0x80000000 (underflow)
- Stall: issue 3 operands, pull en low for 5 cycles mid-stream with vld_in toggling → outputs and vld_out freeze; after en returns, exactly 3 results come out, in order, uncorrupted.
- Bubbles: pattern vld_in=1,0,1 with en=1 → vld_out pattern 1,0,1; result_out holds the first result during the bubble.
- Reset with 2 ops in flight → vld_out=0 immediately; after release no stale results. RNE build: random sweep against a reference model, bit-exact; truncate build: result ≤ reference and within 1 ULP.
